// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR output framer.
// Holds the default sample width, input FSM states and clog2.
package fir_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } in_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_sm_framer_if.sv
// AXI-Stream beat bundle shared by the framer's input and output.
// master drives the beat, slave drives back-pressure.
interface fir_sm_framer_if
  import fir_pkg::*;
#(
  parameter int DW = DATA_W
) ();

  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tready;

  modport master (
    output tvalid, tdata, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast,
    output tready
  );

endinterface

// File: rtl/fir_sync_fifo.sv
// Flop-based synchronous FIFO with occupancy level.
// Head entry is read straight from storage, so output is register-fed.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter  int W     = 33,
  parameter  int DEPTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      if (do_push) mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fir_sm_framer.sv
// Buffers FIR output, regenerates tlast from a frame length,
// flags upstream tlast disagreement and counts output frames.
module fir_sm_framer
  import fir_pkg::*;
#(
  parameter  int pDATA_WIDTH = DATA_W,
  parameter  int pDEPTH      = 8,
  parameter  int pLEN_WIDTH  = 16,
  localparam int LVW         = clog2(pDEPTH) + 1
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic [pLEN_WIDTH-1:0] data_length,
  input  logic                  clear_err,
  fir_sm_framer_if.slave        ss,
  fir_sm_framer_if.master       sm,
  output logic [LVW-1:0]        level,
  output logic                  err_tlast,
  output logic                  frame_done,
  output logic [pLEN_WIDTH-1:0] frame_cnt
);

  localparam int L = pLEN_WIDTH;
  localparam int W = pDATA_WIDTH + 1;

  in_state_e    state_q, state_d;
  logic [L-1:0] len_q, len_d;
  logic [L-1:0] idx_q, idx_d;
  logic [L-1:0] len_eff;
  logic [L-1:0] cnt_q;
  logic         rdy_q, err_q, err_d, done_q;
  logic         full, empty, accept, pop, tag;
  logic [W-1:0] rdata;

  // ready held low until the first edge after reset release
  assign ss.tready = rdy_q & ~full;
  assign accept    = ss.tvalid & ss.tready;
  assign sm.tvalid = ~empty;
  assign pop       = sm.tvalid & sm.tready;
  assign sm.tlast  = rdata[W-1];
  assign sm.tdata  = rdata[W-2:0];

  // a new frame samples data_length; mid-frame uses the latched copy
  assign len_eff = (state_q == IDLE) ? data_length : len_q;
  assign tag     = (len_eff != '0) ? (idx_q == len_eff - L'(1))
                                   : ss.tlast;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (accept) begin
      if (state_q == IDLE) len_d = data_length;
      if (tag) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        state_d = ACTIVE;
        idx_d   = idx_q + L'(1);
      end
    end
    if (clear_err) err_d = 1'b0;
    if (accept && (len_eff != '0) && (ss.tlast != tag))
      err_d = 1'b1;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rdy_q   <= 1'b1;
      err_q   <= err_d;
      done_q  <= pop & sm.tlast;
      if (pop & sm.tlast) cnt_q <= cnt_q + L'(1);
    end
  end

  fir_sync_fifo #(
    .W     (W),
    .DEPTH (pDEPTH)
  ) u_fifo (
    .clk_i   (axis_clk),
    .rst_ni  (axis_rst_n),
    .push_i  (accept),
    .wdata_i ({tag, ss.tdata}),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign err_tlast  = err_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fir_sm_framer.sv
// Self-checking bench for fir_sm_framer: vector table, scoreboard
// and hand-written back-pressure / reset sequences.
module tb_fir_sm_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] dlen;
  logic        clr;
  logic [3:0]  level;
  logic        err, done;
  logic [15:0] fcnt;

  fir_sm_framer_if #(.DW(32)) ss_if ();
  fir_sm_framer_if #(.DW(32)) sm_if ();

  fir_sm_framer dut (
    .axis_clk    (clk),
    .axis_rst_n  (rst_n),
    .data_length (dlen),
    .clear_err   (clr),
    .ss          (ss_if),
    .sm          (sm_if),
    .level       (level),
    .err_tlast   (err),
    .frame_done  (done),
    .frame_cnt   (fcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dl;
    logic [31:0] d;
    logic        tl;
    logic        el;
    logic        mis;
    logic        c;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_err, m_done, hold;
  logic [15:0] m_cnt;
  logic [32:0] hold_v;
  logic        cur_el, cur_mis;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [15:0] dl,
                              input logic [31:0] d,
                              input logic tl, el, mis, c);
    vec_t v;
    v.dl = dl; v.d = d; v.tl = tl;
    v.el = el; v.mis = mis; v.c = c;
    tbl.push_back(v);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      logic [32:0] e;
      chk("level", level, sb.size());
      chk("sm_tvalid", sm_if.tvalid, sb.size() != 0);
      chk("err_tlast", err, m_err);
      chk("frame_cnt", fcnt, m_cnt);
      chk("frame_done", done, m_done);
      if (hold)
        chk("hold", {sm_if.tlast, sm_if.tdata}, hold_v);
      hold   = sm_if.tvalid & ~sm_if.tready;
      hold_v = {sm_if.tlast, sm_if.tdata};
      m_done = 1'b0;
      if (sm_if.tvalid && sm_if.tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat actual=%0h required=none",
                   sm_if.tdata);
        end else begin
          e = sb.pop_front();
          if ({sm_if.tlast, sm_if.tdata} !== e) begin
            errors++;
            $display("FAIL sm_out actual=%0h required=%0h",
                     {sm_if.tlast, sm_if.tdata}, e);
          end
          if (e[32]) begin
            m_done = 1'b1;
            m_cnt  = m_cnt + 16'd1;
          end
        end
      end
      if (ss_if.tvalid && ss_if.tready) begin
        sb.push_back({cur_el, ss_if.tdata});
        if (cur_mis) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
      end else if (clr) begin
        m_err = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic tl, el,
                      input logic mis, c);
    int n;
    n = 0;
    ss_if.tvalid = 1'b1;
    ss_if.tdata  = d;
    ss_if.tlast  = tl;
    cur_el  = el;
    cur_mis = mis;
    clr     = c;
    @(negedge clk);
    while (!ss_if.tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stuck required=accept");
    end
    @(posedge clk); #1;
    ss_if.tvalid = 1'b0;
    clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sm_if.tvalid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", sm_if.tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_cnt", fcnt, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    chk("rst_tready", ss_if.tready, 0);
    chk("rst_tdata", sm_if.tdata, 0);
    chk("rst_tlast", sm_if.tlast, 0);
    sb.delete();
    m_err = 0; m_cnt = 0; m_done = 0; hold = 0;
    ss_if.tvalid = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel_tready0", ss_if.tready, 0);
    @(posedge clk); #1;
    chk("rel_tready1", ss_if.tready, 1);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      dlen = tbl[i].dl;
      send(tbl[i].d, tbl[i].tl, tbl[i].el, tbl[i].mis, tbl[i].c);
    end
  endtask

  initial begin
    ss_if.tvalid = 0; ss_if.tdata = 0; ss_if.tlast = 0;
    sm_if.tready = 0; dlen = 0; clr = 0;
    cur_el = 0; cur_mis = 0;
    m_err = 0; m_cnt = 0; m_done = 0; hold = 0;
    for (int k = 1; k <= 8; k++)
      add(16'd4, k, k == 4 || k == 8, k == 4 || k == 8, 0, 0);
    for (int k = 9; k <= 12; k++)
      add(16'd4, k, k == 11, k == 12, k >= 11, k == 12);
    for (int k = 21; k <= 25; k++)
      add(16'd0, k, k == 22 || k == 25, k == 22 || k == 25, 0, 0);
    add(16'd1, 30, 1, 1, 0, 0);
    add(16'd1, 31, 1, 1, 0, 0);

    #2;
    do_reset();
    sm_if.tready = 1'b1;

    run_rows(0, 7);
    drain();
    chk("t1_cnt", fcnt, 2);
    chk("t1_err", err, 0);

    run_rows(8, 11);
    drain();
    chk("t2_err_set", err, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    chk("t2_err_clr", err, 0);

    run_rows(12, 18);
    drain();
    chk("t5_err", err, 0);
    chk("t5_cnt", fcnt, 7);

    dlen = 16'd5;
    sm_if.tready = 1'b0;
    fork
      for (int k = 0; k < 10; k++)
        send(100 + k, (k % 5) == 4, (k % 5) == 4, 0, 0);
      begin
        int n;
        n = 0;
        while (level != 4'd8 && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        chk("fill_level", level, 8);
        chk("fill_ready", ss_if.tready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_level", level, 8);
        chk("full_accepts", sb.size(), 8);
        sm_if.tready = 1'b1;
      end
    join
    drain();
    chk("t3_cnt", fcnt, 9);

    dlen = 16'd3;
    fork
      for (int k = 0; k < 6; k++)
        send(200 + k, (k % 3) == 2, (k % 3) == 2, 0, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        sm_if.tready = 1'b0;
        @(posedge clk); #1;
        sm_if.tready = 1'b1;
      end
    join
    drain();
    chk("t4_cnt", fcnt, 11);

    dlen = 16'd8;
    sm_if.tready = 1'b0;
    for (int k = 0; k < 5; k++) send(300 + k, 0, 0, 0, 0);
    chk("pre_rst_level", level, 5);
    #2;
    do_reset();
    dlen = 16'd4;
    sm_if.tready = 1'b1;
    for (int k = 0; k < 4; k++)
      send(400 + k, k == 3, k == 3, 0, 0);
    drain();
    chk("t6_cnt", fcnt, 1);
    chk("t6_err", err, 0);
    chk("t6_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
